rr_mux_n: RTL
=============

# rr_mux_n

Parametrised N-channel registered multiplexer with built-in request encoding. It is the successor to the team's fixed 4-input one-hot selector/encoder. It accepts up to N valid/ready input streams, picks one per cycle by round-robin or fixed priority, and presents the chosen word together with its binary channel index on a single registered valid/ready output. It sits between the per-channel producers and any single shared consumer.

## Interface
- N, default 4: number of input channels; N ≥ 2, need not be a power of two.
- W, default 8: data width per channel.
- MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- IDXW (localparam): $clog2(N).

Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: grant enable; 0 blocks new grants while the output still drains.
- in_valid, input, N: per-channel request.
- in_data, input, N*W: channel k occupies bits [k*W +: W].
- in_ready, output, N: one-hot or zero; high on the channel accepted this cycle.
- out_valid, output, 1: output register holds a word.
- out_data, output, W: selected word.
- out_idx, output, IDXW: binary index of the channel that supplied out_data.
- out_ready, input, 1: consumer accepts the word when out_valid & out_ready.

## Operation
- Two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = en & (EMPTY | out_ready). A grant happens when can_load and |in_valid.
- Grant selection:
  - MODE=1: lowest-index asserted in_valid.
  - MODE=0: first asserted in_valid at or after ptr, scanning upward and wrapping from N-1 to 0.
- On a grant to channel k:
  - in_ready[k]=1 in the same cycle; this is the transfer.
  - Next edge: out_data ← channel k data, out_idx ← k, state → FULL.
  - MODE=0 only: ptr ← (k==N-1) ? 0 : k+1. ptr holds when there is no grant. ptr is unused in MODE=1.
- FULL & out_ready & no grant: state → EMPTY. out_data and out_idx hold their last values.
- FULL & !out_ready: out_data and out_idx are stable; in_ready is all zero.
- en=0: in_ready is all zero, and out_valid/out_ready behave normally, so a held word can still drain.
- in_ready depends combinationally on in_valid, en, out_ready and state. It never depends on itself.
- A request not granted stays pending; the block does not drop or reorder data within a channel.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, in_ready=0, ptr=0, state EMPTY.
- Reset asserted mid-operation clears everything immediately (asynchronous); a held word is lost.
- Latency: 1 cycle from in_valid[k]&in_ready[k] to out_valid with that word.
- Throughput: 1 word/cycle with out_ready held high.
- Simultaneous pop and grant in FULL: the new word replaces the old one in the same edge; out_valid stays 1.
- Round-robin fairness: with all N requesting continuously, every channel is served exactly once per N grants.

## Structure
- Package rr_mux_pkg holds the mode constants MODE_RR=0 and MODE_FIXED=1.
- Sub-module rr_pick (combinational): inputs req[N] and ptr[IDXW]; outputs gnt_onehot[N], gnt_idx[IDXW] and any_gnt. It implements the masked double-scan priority encoder and is the generalisation of the old one-hot encoder.
- The top level contains only the FSM, ptr, the output register and the data mux indexed by gnt_idx.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → out_valid/out_idx/out_data drop to 0 without waiting for a clock edge; after release, first grant goes to channel 0.
- RR, N=4, W=8: all in_valid=1111, out_ready=1, channel k data=0x10+k → out_idx sequence 0,1,2,3,0,… and out_data 0x10,0x11,0x12,0x13,0x10.
- Back-pressure: out_ready=0 for 3 cycles after out_data=0x11 → out_data holds 0x11, in_ready=0000; release → next word is 0x12 on the following cycle.
- Fixed priority (MODE=1): in_valid=1010 constant → only channel 1 is granted every cycle; channel 3 is granted only after in_valid[1] drops.
- Wrap and non-power-of-two: N=3, ptr=2, in_valid=011 → channel 0 granted, ptr → 1. Then in_valid=100 → channel 2 granted, ptr → 0.
- Enable: en=0 with in_valid=1111 and a word held → the word drains on out_ready, then out_valid=0 and in_ready stays 0000 until en=1.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the rr_mux_n channel multiplexer.
package rr_mux_pkg;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Masked double-scan priority encoder: first request at or above ptr,
// otherwise first request from index 0 (wrap-around).
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any_gnt
);

    // Scan the masked upper range first, then fall back to a full scan.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (i >= 32'(ptr))) begin
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDXW'(i);
                any_gnt       = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_gnt && req[i]) begin
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDXW'(i);
                any_gnt       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered valid/ready multiplexer with round-robin or fixed
// priority arbitration and binary channel index on the output.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = MODE_RR,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    input  logic            out_ready
);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] pick_ptr;
    logic [N-1:0]    gnt_onehot;
    logic [IDXW-1:0] gnt_idx;
    logic            any_gnt;
    logic            can_load;
    logic            grant;
    logic [W-1:0]    sel_data;

    // Fixed priority is round-robin with the scan origin pinned at 0.
    assign pick_ptr = (MODE == MODE_FIXED) ? '0 : ptr;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req        (in_valid),
        .ptr        (pick_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    // No transfer is offered while reset is held, since it would be lost.
    assign can_load  = en & ((state == EMPTY) | out_ready);
    assign grant     = can_load & any_gnt & ~rst;
    assign in_ready  = grant ? gnt_onehot : '0;
    assign out_valid = (state == FULL);

    // Select the granted channel's word.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == IDXW'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output register FSM: load on grant, drain on pop, advance ptr past winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else if (grant) begin
            state    <= FULL;
            out_data <= sel_data;
            out_idx  <= gnt_idx;
            if (MODE == MODE_RR) begin
                ptr <= (gnt_idx == IDXW'(N-1)) ? '0 : gnt_idx + IDXW'(1);
            end
        end else if ((state == FULL) && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule
